// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// the NOP word presented when no instruction is valid, and the default
// post-reset fetch address.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,  // request outstanding, result will be captured
        READY   = 2'd1,  // instruction presented, no request outstanding
        DISCARD = 2'd2   // request outstanding, result will be thrown away
    } fetch_state_e;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one instruction-memory read at a time,
// presents the returned word to the IF/ID register, and handles decode
// redirects (including redirects that land while a read is still in flight).
// Optional feature: define FETCH_PERF_EN to add fetch/redirect counters.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] RD,
    output logic [31:0] PCplus4F,
    output logic [31:0] PCF,
    output logic        fetch_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_redirect_cnt
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pcf_q, pcf_d;
    logic [31:0]  rd_q, rd_d;
    logic [31:0]  pc4_q, pc4_d;
    logic         valid_q, valid_d;
    logic [31:0]  pend_q, pend_d;
    logic         armed_q;
    logic         ack_ok;
    logic         capture;

    // An ack seen on the first edge after reset release belongs to a request
    // that reset abandoned, so acks only count once the unit is armed.
    assign ack_ok = imem_ack & armed_q;

    // Arm one edge after reset is released.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            pcf_q   <= RESET_PC;
            rd_q    <= NOP;
            pc4_q   <= NOP;
            valid_q <= 1'b0;
            pend_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            pcf_q   <= pcf_d;
            rd_q    <= rd_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
        end
    end

    // Next-state and request logic; PC arithmetic wraps naturally at 32 bits.
    always_comb begin
        state_d  = state_q;
        pcf_d    = pcf_q;
        rd_d     = rd_q;
        pc4_d    = pc4_q;
        valid_d  = valid_q;
        pend_d   = pend_q;
        imem_req = 1'b1;
        capture  = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (PCSrcD) begin
                    if (ack_ok) begin
                        // Data for the old path arrived with the redirect: drop it.
                        pcf_d = PCBranchD;
                    end else begin
                        // Read still in flight: remember target, drain the read.
                        pend_d  = PCBranchD;
                        state_d = DISCARD;
                    end
                end else if (ack_ok) begin
                    rd_d    = imem_rdata;
                    pc4_d   = pcf_q + PC_STEP;
                    pcf_d   = pcf_q + PC_STEP;
                    valid_d = 1'b1;
                    capture = 1'b1;
                    state_d = READY;
                end
            end
            DISCARD: begin
                // A newer redirect supersedes the one already pending.
                if (PCSrcD) begin
                    pend_d = PCBranchD;
                end
                if (ack_ok) begin
                    pcf_d   = PCSrcD ? PCBranchD : pend_q;
                    state_d = FETCH;
                end
            end
            READY: begin
                imem_req = 1'b0;
                // Redirect beats stall; both a redirect and a consume free the slot.
                if (PCSrcD || !StallF) begin
                    if (PCSrcD) begin
                        pcf_d = PCBranchD;
                    end
                    rd_d    = NOP;
                    pc4_d   = NOP;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign imem_addr   = pcf_q;
    assign PCF         = pcf_q;
    assign RD          = rd_q;
    assign PCplus4F    = pc4_q;
    assign fetch_valid = valid_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] redir_cnt_q;

    // Free-running event counters; they wrap at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt_q <= 32'h0;
            redir_cnt_q <= 32'h0;
        end else begin
            if (capture) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (PCSrcD) begin
                redir_cnt_q <= redir_cnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt    = fetch_cnt_q;
    assign perf_redirect_cnt = redir_cnt_q;
`else
    logic unused_capture;
    assign unused_capture = capture;
`endif

endmodule : fetch_unit

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  meaning the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  meaning asynchronous, active-low reset.
REQ-004 SHALL have port StallF  input  1  meaning hazard stall: hold the presented instruction and issue no new fetch.
REQ-005 SHALL have port PCSrcD  input  1  meaning branch/jump redirect taken in decode.
REQ-006 SHALL have port PCBranchD  input  32  meaning the redirect target, sampled when PCSrcD=1.
REQ-007 SHALL have port imem_req  output  1  meaning instruction-memory read request.
REQ-008 SHALL have port imem_addr  output  32  meaning the read address, equal to PCF.
REQ-009 SHALL have port imem_ack  input  1  meaning imem_rdata is valid this cycle and the request is complete.
REQ-010 SHALL have port imem_rdata  input  32  meaning the fetched instruction word.
REQ-011 SHALL have port RD  output  32  meaning the instruction presented to the IF/ID register; 32'h0 (NOP) when not valid.
REQ-012 SHALL have port PCplus4F  output  32  meaning the address of the presented instruction plus 4.
REQ-013 SHALL have port PCF  output  32  meaning the current fetch PC.
REQ-014 SHALL have port fetch_valid  output  1  meaning RD/PCplus4F hold a real instruction.

Function
REQ-015 SHALL implement states FETCH, READY, DISCARD; imem_req=1 in FETCH and DISCARD, 0 in READY.
REQ-016 SHALL keep imem_addr stable while imem_req=1 and the request is unacknowledged.
REQ-017 In FETCH, on imem_ack with PCSrcD=0: RD<=imem_rdata, PCplus4F<=PCF+4, PCF<=PCF+4, fetch_valid<=1, next state READY.
REQ-018 In FETCH, on PCSrcD=1 with imem_ack=1 in the same cycle: data dropped, PCF<=PCBranchD, fetch_valid stays 0, state stays FETCH.
REQ-019 In FETCH, on PCSrcD=1 without imem_ack: PCBranchD captured into the pending-target register, next state DISCARD.
REQ-020 In DISCARD, on imem_ack: data dropped, PCF<=pending target, next state FETCH; a further PCSrcD in DISCARD overwrites the pending target.
REQ-021 In READY with StallF=1 and PCSrcD=0: RD, PCplus4F, PCF and fetch_valid held unchanged.
REQ-022 In READY with StallF=0 and PCSrcD=0: the instruction is consumed at this edge; RD<=0, PCplus4F<=0, fetch_valid<=0, next state FETCH.
REQ-023 In READY with PCSrcD=1: PCF<=PCBranchD, RD<=0, PCplus4F<=0, fetch_valid<=0, next state FETCH; PCSrcD takes priority over StallF.
REQ-024 SHALL perform all PC arithmetic modulo 2^32, so that 32'hFFFFFFFC+4 wraps to 32'h00000000.
REQ-025 SHALL give a minimum latency of one cycle from imem_ack to fetch_valid=1 and two cycles per instruction at zero memory wait.

Reset
REQ-026 While reset=0: state=FETCH, PCF=RESET_PC, RD=0, PCplus4F=0, fetch_valid=0, pending target=0, imem_req=1 once released.
REQ-027 Reset asserted mid-request SHALL abandon that request; an imem_ack arriving in the cycle reset is released SHALL be ignored.

Configuration
REQ-028 With FETCH_PERF_EN defined: outputs perf_fetch_cnt[31:0] (incremented on each REQ-017 capture) and perf_redirect_cnt[31:0] (incremented on each PCSrcD=1 cycle), both reset to 0 and wrapping.
REQ-029 Without FETCH_PERF_EN: those ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-030 SHALL place the state encoding (FETCH/READY/DISCARD), the NOP constant 32'h0 and the RESET_PC default in the shared package.
REQ-031 SHALL be a single module with no sub-module; the perf counters stay inline under the macro.

Verification
REQ-032 Reset release, ack after 0 wait cycles with rdata=32'h20080005 -> imem_addr=0, then RD=32'h20080005, PCplus4F=4, PCF=4, fetch_valid=1 one cycle later.
REQ-033 StallF=1 held for 3 cycles in READY -> RD/PCplus4F/PCF unchanged and imem_req=0 throughout; normal flow resumes on release.
REQ-034 PCSrcD=1 with PCBranchD=32'h40 while the ack is delayed by 3 cycles -> state DISCARD, old data dropped, next imem_addr=32'h40.
REQ-035 PCSrcD=1 together with imem_ack -> fetch_valid stays 0 and next imem_addr=PCBranchD.
REQ-036 PCF=32'hFFFFFFFC with ack -> PCplus4F=0 and PCF=0; reset pulsed during a wait -> all outputs return to their reset values asynchronously.
REQ-037 With FETCH_PERF_EN defined: 5 fetches and 2 redirects -> perf_fetch_cnt=5 and perf_redirect_cnt=2.
